// File: rtl/dp_fsm_ctrl_if.sv
// Token handshake bundle for dp_fsm_ctrl: two input tokens and two buffered
// output streams. master = controller side, slave = producer/consumer side.
interface dp_fsm_ctrl_if #(
    parameter int W = 8
);
    logic         i1_valid;
    logic         i2_valid;
    logic         i1_ack;
    logic         i2_ack;
    logic [W-1:0] o1_data;
    logic         o1_valid;
    logic         o1_ready;
    logic [W-1:0] o2_data;
    logic         o2_valid;
    logic         o2_ready;

    modport master (
        input  i1_valid,
        input  i2_valid,
        output i1_ack,
        output i2_ack,
        output o1_data,
        output o1_valid,
        input  o1_ready,
        output o2_data,
        output o2_valid,
        input  o2_ready
    );

    modport slave (
        output i1_valid,
        output i2_valid,
        input  i1_ack,
        input  i2_ack,
        input  o1_data,
        input  o1_valid,
        output o1_ready,
        input  o2_data,
        input  o2_valid,
        output o2_ready
    );
endinterface

// File: rtl/dp_fsm_ctrl.sv
// Controller for a 4-state datapath: fires when both input tokens are present
// and both 1-entry output buffers can accept, and steps S1..S4 from f1/f2.
// Ports: clock, reset (async active-low), bus (dp_fsm_ctrl_if.master: i1/i2
//   valid/ack, o1/o2 data/valid/ready), state[1:0], fire, f1, f2,
//   dp_o1/dp_o2 [W-1:0], done.
// Optional feature: define DPC_ITER_LIMIT_EN to cap consecutive S4 firings
//   at MAX_ITER, after which the controller returns to S1 regardless of f2.
module dp_fsm_ctrl #(
    parameter int W        = 8,
    parameter int MAX_ITER = 15
) (
    input  logic           clock,
    input  logic           reset,
    dp_fsm_ctrl_if.master  bus,
    output logic [1:0]     state,
    output logic           fire,
    input  logic           f1,
    input  logic           f2,
    input  logic [W-1:0]   dp_o1,
    input  logic [W-1:0]   dp_o2,
    output logic           done
);

    typedef enum logic [1:0] {
        S1 = 2'd0,
        S2 = 2'd1,
        S3 = 2'd2,
        S4 = 2'd3
    } st_t;

    st_t          st_q;
    logic [W-1:0] o1_d_q;
    logic [W-1:0] o2_d_q;
    logic         o1_v_q;
    logic         o2_v_q;
    logic         done_q;
    logic         o1_free;
    logic         o2_free;

`ifdef DPC_ITER_LIMIT_EN
    localparam int IW = $clog2(MAX_ITER + 1);

    logic [IW-1:0] iter_q;
    logic [IW-1:0] iter_nx;

    assign iter_nx = iter_q + IW'(1);
`endif

    // A slot is free if empty or being drained this cycle, which lets a
    // token be taken and refilled in the same cycle.
    assign o1_free = !o1_v_q || bus.o1_ready;
    assign o2_free = !o2_v_q || bus.o2_ready;

    // Gate with reset so nothing is consumed while the block is held.
    assign fire = reset && bus.i1_valid && bus.i2_valid
               && o1_free && o2_free;

    assign bus.i1_ack   = fire;
    assign bus.i2_ack   = fire;
    assign bus.o1_data  = o1_d_q;
    assign bus.o1_valid = o1_v_q;
    assign bus.o2_data  = o2_d_q;
    assign bus.o2_valid = o2_v_q;
    assign state        = st_q;
    assign done         = done_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q   <= S1;
            o1_d_q <= '0;
            o2_d_q <= '0;
            o1_v_q <= 1'b0;
            o2_v_q <= 1'b0;
            done_q <= 1'b0;
`ifdef DPC_ITER_LIMIT_EN
            iter_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (fire) begin
                // New data wins over a same-cycle drain.
                o1_d_q <= dp_o1;
                o2_d_q <= dp_o2;
                o1_v_q <= 1'b1;
                o2_v_q <= 1'b1;
                unique case (st_q)
                    S1: begin
                        st_q <= S2;
                    end
                    S2: begin
                        st_q <= f1 ? S3 : S1;
                    end
                    S3: begin
                        if (f2) begin
                            st_q <= S4;
`ifdef DPC_ITER_LIMIT_EN
                            iter_q <= '0;
`endif
                        end else begin
                            st_q   <= S1;
                            done_q <= 1'b1;
                        end
                    end
                    S4: begin
`ifdef DPC_ITER_LIMIT_EN
                        if (!f2 || iter_nx == IW'(MAX_ITER)) begin
                            st_q   <= S1;
                            done_q <= 1'b1;
                            iter_q <= '0;
                        end else begin
                            iter_q <= iter_nx;
                        end
`else
                        if (!f2) begin
                            st_q   <= S1;
                            done_q <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        st_q <= S1;
                    end
                endcase
            end else begin
                if (bus.o1_ready) o1_v_q <= 1'b0;
                if (bus.o2_ready) o2_v_q <= 1'b0;
            end
        end
    end

endmodule
